// File: rtl/button_event_pkg.sv
// button_event_pkg: shared state type and default timing constants for button_event
package button_event_pkg;
  typedef enum logic [2:0] {IDLE, HELD, LONG, WAIT, HELD2} btn_state_t;
  localparam int CLK_HZ = 10000;
  localparam int LONG_CYCLES_DEFAULT = CLK_HZ;
  localparam int DCLICK_GAP_DEFAULT = CLK_HZ * 3 / 10;
endpackage

// File: rtl/button_event_edge.sv
// button_edge: previous-sample register and registered press/release edge strobes
// Ports: clk, reset_n (async active-low), btn_in level in; prev sample, press_pulse, release_pulse out.
module button_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic prev,
  output logic press_pulse,
  output logic release_pulse
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      prev <= btn_in;
      press_pulse <= btn_in & ~prev;
      release_pulse <= ~btn_in & prev;
    end
endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release, click, double-click and long-press strobes
// Ports: clk, reset_n (async active-low), btn_in level; press_pulse, release_pulse, click, dbl_click, long_press strobes.
// Macro BUTTON_EVENT_DOUBLE_CLICK_EN adds the WAIT/HELD2 double-click path; without it clicks are immediate.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT,
  parameter int DCLICK_GAP = DCLICK_GAP_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic dbl_click,
  output logic long_press
);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  if (LONG_CYCLES < 2 || DCLICK_GAP < 2) begin : g_bad
    $error("button_event: LONG_CYCLES and DCLICK_GAP must be >= 2");
  end
  btn_state_t state;
  logic prev, press, rel;
  logic [HW-1:0] hold_cnt;
  logic hold_long;
  button_edge u_edge (
    .clk(clk),
    .reset_n(reset_n),
    .btn_in(btn_in),
    .prev(prev),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );
  assign press = btn_in & ~prev;
  assign rel = ~btn_in & prev;
  // hold_cnt counts high samples seen so far; the press sample itself loads 1
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hold_cnt <= '0;
    else hold_cnt <= press ? HW'(1) : (btn_in && hold_cnt != HW'(LONG_CYCLES)) ? hold_cnt + HW'(1) : hold_cnt;
  // current sample is the LONG_CYCLES-th consecutive high one
  assign hold_long = btn_in && hold_cnt == HW'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam int GW = $clog2(DCLICK_GAP + 1);
  logic [GW-1:0] gap_cnt;
  // gap_cnt holds (cycles since release - 1) at each WAIT edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) gap_cnt <= '0;
    else if (rel) gap_cnt <= '0;
    else if (state == WAIT) gap_cnt <= gap_cnt + GW'(1);
`else
  assign dbl_click = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      click <= 1'b0;
      long_press <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      dbl_click <= 1'b0;
`endif
    end else begin
      click <= 1'b0;
      long_press <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      dbl_click <= 1'b0;
`endif
      case (state)
        IDLE: if (press) state <= HELD;
        HELD:
          if (!btn_in) begin
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
            state <= WAIT;
`else
            click <= 1'b1;
            state <= IDLE;
`endif
          end else if (hold_long) begin
            long_press <= 1'b1;
            state <= LONG;
          end
        LONG: if (!btn_in) state <= IDLE;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
        // a press landing exactly on the gap deadline closes the old click and starts a new press
        WAIT:
          if (gap_cnt == GW'(DCLICK_GAP - 1)) begin
            click <= 1'b1;
            state <= press ? HELD : IDLE;
          end else if (press) state <= HELD2;
        HELD2:
          if (!btn_in) begin
            dbl_click <= 1'b1;
            state <= IDLE;
          end else if (hold_long) begin
            long_press <= 1'b1;
            state <= LONG;
          end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed checks of button_event strobes with LONG_CYCLES=8, DCLICK_GAP=5
module tb_button_event;
  localparam int L = 8, G = 5;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, btn_in = 1'b0;
  logic press_pulse, release_pulse, click, dbl_click, long_press;
  int checks = 0, errors = 0, cyc = 0;
  int n_press, n_rel, n_click, n_dbl, n_long, t_rel, t_click, f_click, t_long;
  int multi = 0, wide = 0;
  logic [4:0] last = '0;
  always #5 clk = ~clk;
  button_event #(.LONG_CYCLES(L), .DCLICK_GAP(G)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_in(btn_in),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .click(click),
    .dbl_click(dbl_click),
    .long_press(long_press)
  );
  function automatic logic [4:0] outs();
    return {press_pulse, release_pulse, click, dbl_click, long_press};
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    cyc = 0;
    {n_press, n_rel, n_click, n_dbl, n_long} = '0;
    {t_rel, t_click, f_click, t_long} = '0;
  endtask
  task automatic step(input logic b);
    logic [4:0] o;
    btn_in = b;
    @(posedge clk);
    #1;
    cyc++;
    o = outs();
    if (press_pulse) n_press++;
    if (release_pulse) begin n_rel++; t_rel = cyc; end
    if (click) begin n_click++; t_click = cyc; if (n_click == 1) f_click = cyc; end
    if (dbl_click) n_dbl++;
    if (long_press) begin n_long++; t_long = cyc; end
    if (int'(click) + int'(dbl_click) + int'(long_press) > 1) multi++;
    if ((o & last) != 0) wide++;
    last = o;
  endtask
  task automatic run(input logic b, input int n);
    repeat (n) step(b);
  endtask
  initial begin
    btn_in = 1'b1;
    step(1'b1);
    chk("rst_outs_a", int'(outs()), 0);
    run(1'b1, 2);
    chk("rst_outs_b", int'(outs()), 0);
    reset_n = 1'b1;
    clr();
    step(1'b1);
    chk("rst_first_press", int'(outs()), 5'b10000);
    step(1'b1);
    chk("press_one_cycle", int'(outs()), 0);
    run(1'b1, 18);
    chk("hold_long_cnt", n_long, 1);
    chk("hold_long_time", t_long, L);
    chk("hold_press_cnt", n_press, 1);
    step(1'b0);
    chk("hold_release", int'(outs()), 5'b01000);
    run(1'b0, 10);
    chk("hold_no_click", n_click, 0);
    // short press of 3
    clr();
    run(1'b1, 3);
    step(1'b0);
    run(1'b0, 9);
    chk("short_rel_time", t_rel, 4);
    chk("short_click_cnt", n_click, 1);
    chk("short_click_delay", t_click - t_rel, DC ? G : 0);
    chk("short_no_dbl", n_dbl, 0);
    // two short presses with a 2-cycle gap
    clr();
    run(1'b1, 3);
    run(1'b0, 2);
    run(1'b1, 3);
    step(1'b0);
    run(1'b0, 10);
    chk("dbl_press_cnt", n_press, 2);
    chk("dbl_dbl_cnt", n_dbl, DC ? 1 : 0);
    chk("dbl_click_cnt", n_click, DC ? 0 : 2);
    // 7 samples is short, 8 is long
    clr();
    run(1'b1, L - 1);
    step(1'b0);
    run(1'b0, 9);
    chk("p7_long", n_long, 0);
    chk("p7_click", n_click, 1);
    clr();
    run(1'b1, L);
    step(1'b0);
    run(1'b0, 9);
    chk("p8_long", n_long, 1);
    chk("p8_long_time", t_long, L);
    chk("p8_click", n_click, 0);
    // second press sampled exactly at the gap deadline
    clr();
    run(1'b1, 3);
    run(1'b0, G);
    run(1'b1, 3);
    step(1'b0);
    run(1'b0, 9);
    chk("gapend_click_cnt", n_click, 2);
    chk("gapend_first_click", f_click, DC ? 9 : 4);
    chk("gapend_no_dbl", n_dbl, 0);
    // reset while a click is pending
    run(1'b1, 3);
    run(1'b0, 3);
    clr();
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", int'(outs()), 0);
    step(1'b0);
    step(1'b0);
    reset_n = 1'b1;
    run(1'b0, 9);
    chk("midrst_no_click", n_click, 0);
    chk("midrst_idle_outs", int'(outs()), 0);
    chk("one_event_per_cycle", multi, 0);
    chk("strobe_width", wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
